memory_stage_v2: RTL
====================

# memory_stage_v2

Parametrised successor to the pipeline memory stage. It sits between execute and writeback and owns the data RAM. It adds byte/halfword/word loads and stores with sign or zero extension, and misalignment detection. It also supports a configurable multi-cycle RAM access latency, with a stall handshake back to the upstream pipeline. The M→W pipeline register is inside the block, as before.

## Interface
- DMEM_POWER, 18, log2 of RAM depth in words
- MEM_LATENCY, 1, cycles per data access (legal 1..4)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- writeDataM, ALUResultM, pcM  in  `WORD  store data, byte address / ALU result, PC
- writeRegM  in  `REG_SIZE  destination register
- regWriteM, memWriteM, mem2regM  in  1  control from execute
- sizeM  in  2  00 byte, 01 half, 10 word (11 treated as word)
- unsignedM  in  1  zero-extend sub-word loads when 1
- zeroM, branchM, finishM, validM  in  1  branch condition, end-of-program, slot valid
- readDataW, ALUResultW, pcW, writeDataW  out  `WORD  registered stage results
- writeRegW  out  `REG_SIZE  registered destination
- regWriteW, mem2regW, memWriteW, finishW, validW, misalignW  out  1  registered flags
- PCSrcM  out  1  combinational branch-taken
- stallM  out  1  combinational; upstream holds the M inputs while this is 1

## Operation
- **Memory access.** A memory access is an op with validM=1 and (memWriteM|mem2regM)=1. Any other op is a non-access and passes to W in one cycle with no stall.
- **Addressing.**
  - Word index = ALUResultM[DMEM_POWER+1:2]; lane = ALUResultM[1:0].
  - Out-of-range upper bits are ignored, so the address wraps.
- **Misalignment.** Half with lane[0]=1, or word with lane≠00, is misaligned.
  - No RAM write and no stall.
  - misalignW=1, regWriteW=0, memWriteW=0.
  - validW and the other fields pass through.
- **Stores.** Per-byte write enables.
  - Byte: writeDataM[7:0] is written to byte lane `lane`.
  - Half: writeDataM[15:0] is written to lanes {lane+1, lane}.
  - Word: all four lanes are written. Unselected bytes are unchanged.
- **Loads.** Read the RAM word, then select by lane.
  - Byte/half: sign-extend, or zero-extend when unsignedM=1.
  - Word: the whole word.
  - The result goes to readDataW.
- **ALUResultW / writeDataW.** Carry the unmodified M values.
- **PCSrcM** = zeroM & branchM & validM.
- **FSM** (used only when MEM_LATENCY>1):
  - IDLE: an aligned access arrives → go to BUSY, load cnt=MEM_LATENCY-2, stallM=1, W register loads a bubble.
  - BUSY, cnt>0: stallM=1, cnt decrements, W loads a bubble.
  - BUSY, cnt=0: stallM=0, RAM write/read commits, W loads the op, return to IDLE.
- **Bubble.** validW=regWriteW=memWriteW=mem2regW=finishW=misalignW=0. Data fields are don't-care but are driven 0.
- **Latency 1.** With MEM_LATENCY=1 the FSM stays in IDLE and stallM is tied to 0.

## Timing
- **Reset.** While reset=0:
  - all W outputs = 0, FSM = IDLE, cnt = 0, stallM = 0.
  - RAM contents are not reset.
- **Access latency.** An aligned access presented in cycle t has:
  - stallM=1 in cycles t..t+L-2;
  - RAM commit and W capture at the rising edge ending cycle t+L-1.
  - L=1 gives the classic one-cycle M→W.
- **Single write.** The store write happens exactly once, on the commit edge, never during stall cycles.
- **Stable inputs.** Upstream holds the M inputs stable while stallM=1. The block samples them only on the commit edge.
- **Load data.** Load data reflects RAM state including any store committed on an earlier edge (read-after-write across consecutive ops).
- **Reset mid-access.** Reset asserted during BUSY aborts the access: no RAM write, FSM back to IDLE.
- **Non-access ops.** A non-access op, or validM=0, in IDLE never asserts stallM.
- **PCSrcM.** Combinational from the current M inputs, including during stall cycles.

## Test plan
- **Reset.** Assert reset=0 mid-run → all W outputs 0, stallM 0. Release, then a non-access op with writeRegM=5, regWriteM=1 → next edge writeRegW=5, regWriteW=1, validW=1.
- **Byte store and sign/zero-extend loads.** Store word 0x11223344 at address 0x40, then byte store 0xAB at address 0x41.
  - Word load at 0x40 → 0x1122AB44.
  - Signed byte load at 0x41 → 0xFFFFFFAB.
  - Unsigned byte load at 0x41 → 0x000000AB.
- **Halfword.** Store half 0x8001 at address 0x42.
  - Signed half load at 0x42 → 0xFFFF8001.
  - Unsigned half load at 0x42 → 0x00008001.
  - Word load at 0x40 → 0x8001AB44.
- **Misalignment.** Word store to 0x45 → no stall, misalignW=1, memWriteW=0, and a word load at 0x44 returns its previous value. Half load at 0x43 → misalignW=1, regWriteW=0.
- **Multi-cycle latency.** MEM_LATENCY=3: load issued at cycle t → stallM=1 for t and t+1, validW=0 after edges t and t+1, data valid after edge t+2. Reset pulsed at t+1 during a store → word unchanged afterwards.
- **Branch and wrap.** zeroM=branchM=validM=1 → PCSrcM=1 the same cycle; validM=0 → PCSrcM=0. Store to address (1<<(DMEM_POWER+2))+8 → readable at address 8.

Source files
------------

// File: rtl/memory_stage_v2.sv
// memory_stage_v2: pipeline memory stage with the data RAM, sub-word loads/stores,
// misalignment detection, configurable access latency and the M->W register.

`ifndef WORD
`define WORD [31:0]
`endif
`ifndef REG_SIZE
`define REG_SIZE [4:0]
`endif

module memory_stage_v2 #(
  parameter int DMEM_POWER  = 18,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic `WORD     writeDataM,
  input  logic `WORD     ALUResultM,
  input  logic `WORD     pcM,
  input  logic `REG_SIZE writeRegM,
  input  logic           regWriteM,
  input  logic           memWriteM,
  input  logic           mem2regM,
  input  logic [1:0]     sizeM,
  input  logic           unsignedM,
  input  logic           zeroM,
  input  logic           branchM,
  input  logic           finishM,
  input  logic           validM,
  output logic `WORD     readDataW,
  output logic `WORD     ALUResultW,
  output logic `WORD     pcW,
  output logic `WORD     writeDataW,
  output logic `REG_SIZE writeRegW,
  output logic           regWriteW,
  output logic           mem2regW,
  output logic           memWriteW,
  output logic           finishW,
  output logic           validW,
  output logic           misalignW,
  output logic           PCSrcM,
  output logic           stallM
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter preload so that stallM covers exactly MEM_LATENCY-1 cycles.
  localparam logic [1:0] CNT_INIT = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

  logic [31:0] ram_q [2**DMEM_POWER];

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic [DMEM_POWER-1:0] wordIdx;
  logic [1:0]  lane;
  logic        isAccess, sizeMisaligned, misaligned, alignedAccess;
  logic        stall, ramWe;
  logic [3:0]  byteEn;
  logic [31:0] storeWord, ramWord, loadData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic        unusedAddrBits;

  logic [31:0] readData_q, readData_d, aluResult_q, aluResult_d;
  logic [31:0] pc_q, pc_d, writeData_q, writeData_d;
  logic [4:0]  writeReg_q, writeReg_d;
  logic        regWrite_q, regWrite_d, mem2reg_q, mem2reg_d, memWrite_q, memWrite_d;
  logic        finish_q, finish_d, valid_q, valid_d, misalign_q, misalign_d;

  // Upper address bits beyond the RAM depth are dropped so addresses wrap.
  assign wordIdx        = ALUResultM[DMEM_POWER+1:2];
  assign lane           = ALUResultM[1:0];
  assign unusedAddrBits = ^ALUResultM[31:DMEM_POWER+2];

  assign isAccess      = validM & (memWriteM | mem2regM);
  assign misaligned    = isAccess & sizeMisaligned;
  assign alignedAccess = isAccess & ~sizeMisaligned;

  assign PCSrcM = zeroM & branchM & validM;
  assign stallM = stall & reset;

  // Alignment rule depends on access size: halves need an even lane, words lane 0.
  always_comb begin
    sizeMisaligned = 1'b0;
    unique case (sizeM)
      2'b00:   sizeMisaligned = 1'b0;
      2'b01:   sizeMisaligned = lane[0];
      default: sizeMisaligned = (lane != 2'b00);
    endcase
  end

  // Latency sequencing: an aligned access in IDLE starts a countdown; commit when it expires.
  always_comb begin
    stall   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (MEM_LATENCY > 1) begin
      unique case (state_q)
        IDLE: begin
          if (alignedAccess) begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt_q != 2'd0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 2'd1;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // Store lane enables and store data replicated so each lane sees its own bytes.
  always_comb begin
    byteEn    = 4'b1111;
    storeWord = writeDataM;
    unique case (sizeM)
      2'b00: begin
        byteEn    = 4'b0001 << lane;
        storeWord = {4{writeDataM[7:0]}};
      end
      2'b01: begin
        byteEn    = lane[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{writeDataM[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeWord = writeDataM;
      end
    endcase
  end

  // The RAM is written only on the commit edge and never while reset is held.
  assign ramWe = reset & ~stall & alignedAccess & memWriteM;

  // Data RAM with byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int k = 0; k < 4; k++) begin
        if (byteEn[k]) begin
          ram_q[wordIdx][8*k +: 8] <= storeWord[8*k +: 8];
        end
      end
    end
  end

  assign ramWord = ram_q[wordIdx];
  assign byteSel = ramWord[{lane, 3'b000} +: 8];
  assign halfSel = lane[1] ? ramWord[31:16] : ramWord[15:0];

  // Lane selection of the read word with sign or zero extension.
  always_comb begin
    loadData = ramWord;
    unique case (sizeM)
      2'b00:   loadData = {{24{~unsignedM & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{~unsignedM & halfSel[15]}}, halfSel};
      default: loadData = ramWord;
    endcase
  end

  // Next W contents: a zero bubble while stalling, otherwise the op with misalignment applied.
  always_comb begin
    readData_d  = '0;
    aluResult_d = '0;
    pc_d        = '0;
    writeData_d = '0;
    writeReg_d  = '0;
    regWrite_d  = 1'b0;
    mem2reg_d   = 1'b0;
    memWrite_d  = 1'b0;
    finish_d    = 1'b0;
    valid_d     = 1'b0;
    misalign_d  = 1'b0;
    if (!stall) begin
      readData_d  = loadData;
      aluResult_d = ALUResultM;
      pc_d        = pcM;
      writeData_d = writeDataM;
      writeReg_d  = writeRegM;
      regWrite_d  = regWriteM & ~misaligned;
      mem2reg_d   = mem2regM;
      memWrite_d  = memWriteM & ~misaligned;
      finish_d    = finishM;
      valid_d     = validM;
      misalign_d  = misaligned;
    end
  end

  // FSM state, countdown and the M->W pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      readData_q  <= '0;
      aluResult_q <= '0;
      pc_q        <= '0;
      writeData_q <= '0;
      writeReg_q  <= '0;
      regWrite_q  <= 1'b0;
      mem2reg_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      finish_q    <= 1'b0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      readData_q  <= readData_d;
      aluResult_q <= aluResult_d;
      pc_q        <= pc_d;
      writeData_q <= writeData_d;
      writeReg_q  <= writeReg_d;
      regWrite_q  <= regWrite_d;
      mem2reg_q   <= mem2reg_d;
      memWrite_q  <= memWrite_d;
      finish_q    <= finish_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign readDataW  = readData_q;
  assign ALUResultW = aluResult_q;
  assign pcW        = pc_q;
  assign writeDataW = writeData_q;
  assign writeRegW  = writeReg_q;
  assign regWriteW  = regWrite_q;
  assign mem2regW   = mem2reg_q;
  assign memWriteW  = memWrite_q;
  assign finishW    = finish_q;
  assign validW     = valid_q;
  assign misalignW  = misalign_q;

endmodule
